// File: rtl/i2s_stream_scheduler_pkg.sv
// Shared types and constants for the I2S stream scheduler.
package i2s_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    RESET_I2S = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } i2s_state_t;

  // Register port addresses
  localparam logic [1:0] ADDR_CLOCK_CONFIG = 2'd0;
  localparam logic [1:0] ADDR_ADC_SCALE    = 2'd1;
  localparam logic [1:0] ADDR_DAC_SCALE    = 2'd2;
  localparam logic [1:0] ADDR_CONTROL      = 2'd3;

  // Control register bit positions
  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_LOOPBACK = 1;
  localparam int CTRL_MUTE     = 2;

  // Width of the ADC/DAC scale fields
  localparam int I2S_SCALE_WIDTH = 6;

endpackage

// File: rtl/i2s_stream_scheduler_sample_fifo.sv
// Synchronous sample FIFO; a push on a full FIFO is accepted when a pop
// happens in the same cycle. Flush empties it without touching storage.
module sample_fifo #(
  parameter int DataWidth = 12,
  parameter int Depth     = 4
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 i_flush,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [DataWidth-1:0] i_wdata,
  output logic [DataWidth-1:0] o_rdata,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int AW = $clog2(Depth);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [AW:0]          r_wptr;
  logic [AW:0]          r_rptr;
  logic                 w_doPush;
  logic                 w_doPop;

  // Extra pointer bit distinguishes full from empty
  assign o_empty  = (r_wptr == r_rptr);
  assign o_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);
  assign o_rdata  = r_mem[r_rptr[AW-1:0]];

  // Pointer update; flush takes priority over push/pop
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_doPush) r_wptr <= r_wptr + 1'b1;
      if (w_doPop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Sample storage, data only so no reset
  always_ff @(posedge clk) begin
    if (w_doPush && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/i2s_stream_scheduler.sv
// Sequences the I2S controller, applies shadow configuration at frame
// boundaries, buffers ADC samples for the DSP and selects the DAC source.
module i2s_stream_scheduler
  import i2s_pkg::*;
#(
  parameter int ClockConfigWidth   = 4,
  parameter int DataWidth          = 12,
  parameter int ScaleWidth         = I2S_SCALE_WIDTH,
  parameter int FifoDepth          = 4,
  parameter int SettleFrames       = 2,
  parameter int DefaultClockConfig = 0,
  parameter int DefaultScale       = 24
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        cfgWrite,
  input  logic [1:0]                  cfgAddr,
  input  logic [7:0]                  cfgWdata,
  output logic                        cfgBusy,
  output logic                        overrun,
  output logic                        underrun,
  output logic                        i2sReset,
  output logic [ClockConfigWidth-1:0] clockConfig,
  output logic [ScaleWidth-1:0]       adcScale,
  output logic [ScaleWidth-1:0]       dacScale,
  input  logic [DataWidth-1:0]        adcData,
  input  logic                        adcDataValid,
  output logic [DataWidth-1:0]        dacData,
  output logic                        dacDataValid,
  output logic [DataWidth-1:0]        rxData,
  output logic                        rxValid,
  input  logic                        rxReady,
  input  logic [DataWidth-1:0]        txData,
  input  logic                        txValid,
  output logic                        txReady
);

  localparam int SettleW = $clog2(SettleFrames + 1);

  i2s_state_t                  r_state, w_stateNext;
  logic                        r_rstCnt;
  logic [SettleW-1:0]          r_settleCnt;
  logic                        r_adcValidPrev;
  logic                        w_tick;
  logic [2:0]                  r_ctrl;
  logic [ClockConfigWidth-1:0] r_clkShadow, r_clkAct;
  logic [ScaleWidth-1:0]       r_adcScaleShadow, r_adcScaleAct;
  logic [ScaleWidth-1:0]       r_dacScaleShadow, r_dacScaleAct;
  logic                        r_pendClk, r_pendScale;
  logic                        w_copyAll, w_copyScale, w_push, w_dacTick;
  logic                        w_wrClk, w_wrAdc, w_wrDac, w_wrCtrl;
  logic [DataWidth-1:0]        r_txHold;
  logic                        r_txFull;
  logic                        w_load, w_holdConsume;
  logic [DataWidth-1:0]        r_dacData, w_dacSrc;
  logic                        r_dacValid;
  logic                        r_overrun, r_underrun;
  logic                        w_overrunEvt, w_underrunEvt;
  logic                        w_fifoFull, w_fifoEmpty, w_pop, w_flush;
  logic                        w_unused;

  assign w_tick   = adcDataValid & ~r_adcValidPrev;
  assign w_wrClk  = cfgWrite & (cfgAddr == ADDR_CLOCK_CONFIG);
  assign w_wrAdc  = cfgWrite & (cfgAddr == ADDR_ADC_SCALE);
  assign w_wrDac  = cfgWrite & (cfgAddr == ADDR_DAC_SCALE);
  assign w_wrCtrl = cfgWrite & (cfgAddr == ADDR_CONTROL);
  assign w_unused = ^cfgWdata;

  // State register and frame-edge detector
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state        <= DISABLED;
      r_adcValidPrev <= 1'b0;
    end else begin
      r_state        <= w_stateNext;
      r_adcValidPrev <= adcDataValid;
    end
  end

  // Next-state logic plus the per-tick actions it authorises
  always_comb begin
    w_stateNext = r_state;
    w_copyAll   = 1'b0;
    w_copyScale = 1'b0;
    w_push      = 1'b0;
    w_dacTick   = 1'b0;
    unique case (r_state)
      DISABLED: begin
        if (r_ctrl[CTRL_ENABLE]) begin
          w_stateNext = RESET_I2S;
          w_copyAll   = 1'b1;
        end
      end
      RESET_I2S: begin
        if (r_rstCnt) w_stateNext = SETTLE;
      end
      SETTLE: begin
        if (w_tick) begin
          w_dacTick = 1'b1;
          if (r_settleCnt == SettleW'(SettleFrames - 1)) w_stateNext = RUN;
        end
      end
      RUN: begin
        if (w_tick) begin
          if (r_pendClk) begin
            // Divider change: drop this frame and restart the controller
            w_stateNext = RESET_I2S;
            w_copyAll   = 1'b1;
          end else begin
            w_push      = 1'b1;
            w_dacTick   = 1'b1;
            w_copyScale = r_pendScale;
          end
        end
      end
      default: w_stateNext = DISABLED;
    endcase
    if (!r_ctrl[CTRL_ENABLE]) begin
      w_stateNext = DISABLED;
      w_copyAll   = 1'b0;
      w_copyScale = 1'b0;
      w_push      = 1'b0;
      w_dacTick   = 1'b0;
    end
  end

  // Reset-hold and settle counters, cleared outside their states
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rstCnt    <= 1'b0;
      r_settleCnt <= '0;
    end else begin
      r_rstCnt <= (r_state == RESET_I2S) & ~r_rstCnt;
      if (r_state != SETTLE)   r_settleCnt <= '0;
      else if (w_tick)         r_settleCnt <= r_settleCnt + 1'b1;
    end
  end

  // Shadow/active configuration; a same-cycle write re-arms its pending flag
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_ctrl           <= '0;
      r_clkShadow      <= ClockConfigWidth'(DefaultClockConfig);
      r_adcScaleShadow <= ScaleWidth'(DefaultScale);
      r_dacScaleShadow <= ScaleWidth'(DefaultScale);
      r_clkAct         <= ClockConfigWidth'(DefaultClockConfig);
      r_adcScaleAct    <= ScaleWidth'(DefaultScale);
      r_dacScaleAct    <= ScaleWidth'(DefaultScale);
      r_pendClk        <= 1'b0;
      r_pendScale      <= 1'b0;
    end else begin
      if (w_wrCtrl) r_ctrl           <= cfgWdata[2:0];
      if (w_wrClk)  r_clkShadow      <= cfgWdata[ClockConfigWidth-1:0];
      if (w_wrAdc)  r_adcScaleShadow <= cfgWdata[ScaleWidth-1:0];
      if (w_wrDac)  r_dacScaleShadow <= cfgWdata[ScaleWidth-1:0];
      if (w_copyAll) r_clkAct <= r_clkShadow;
      if (w_copyAll || w_copyScale) begin
        r_adcScaleAct <= r_adcScaleShadow;
        r_dacScaleAct <= r_dacScaleShadow;
      end
      r_pendClk   <= (r_pendClk & ~w_copyAll) | w_wrClk;
      r_pendScale <= (r_pendScale & ~(w_copyAll | w_copyScale)) | w_wrAdc | w_wrDac;
    end
  end

  // DAC source selection for the current tick
  always_comb begin
    w_dacSrc      = r_dacData;
    w_holdConsume = 1'b0;
    w_underrunEvt = 1'b0;
    if (r_state == SETTLE) begin
      w_dacSrc = '0;
    end else if (r_ctrl[CTRL_MUTE]) begin
      w_dacSrc = '0;
    end else if (r_ctrl[CTRL_LOOPBACK]) begin
      w_dacSrc = adcData;
    end else if (r_txFull) begin
      w_dacSrc      = r_txHold;
      w_holdConsume = w_dacTick;
    end else begin
      w_underrunEvt = w_dacTick;
    end
  end

  assign w_load = txValid & txReady;

  // TX holding register, cleared while disabled
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_txFull <= 1'b0;
      r_txHold <= '0;
    end else if (r_state == DISABLED) begin
      r_txFull <= 1'b0;
    end else if (w_load) begin
      r_txFull <= 1'b1;
      r_txHold <= txData;
    end else if (w_holdConsume) begin
      r_txFull <= 1'b0;
    end
  end

  // DAC output register and its one-cycle load strobe
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_dacData  <= '0;
      r_dacValid <= 1'b0;
    end else begin
      r_dacValid <= w_dacTick;
      if (w_dacTick) r_dacData <= w_dacSrc;
    end
  end

  assign w_flush      = (r_state == DISABLED);
  assign w_pop        = ~w_fifoEmpty & rxReady;
  assign w_overrunEvt = w_push & w_fifoFull & ~w_pop;

  // Sticky error flags; a new event wins over a same-cycle clear
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_wrCtrl) begin
        r_overrun  <= 1'b0;
        r_underrun <= 1'b0;
      end
      if (w_overrunEvt)  r_overrun  <= 1'b1;
      if (w_underrunEvt) r_underrun <= 1'b1;
    end
  end

  sample_fifo #(
    .DataWidth (DataWidth),
    .Depth     (FifoDepth)
  ) u_rx_fifo (
    .clk     (clk),
    .resetN  (resetN),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (adcData),
    .o_rdata (rxData),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  assign rxValid      = ~w_fifoEmpty;
  assign txReady      = ~r_txFull & (r_state == RUN);
  assign i2sReset     = (r_state == DISABLED) | (r_state == RESET_I2S);
  assign clockConfig  = r_clkAct;
  assign adcScale     = r_adcScaleAct;
  assign dacScale     = r_dacScaleAct;
  assign dacData      = r_dacData;
  assign dacDataValid = r_dacValid;
  assign overrun      = r_overrun;
  assign underrun     = r_underrun;
  assign cfgBusy      = r_pendClk | r_pendScale | (r_state == RESET_I2S) |
                        (r_state == SETTLE) | (r_ctrl[CTRL_ENABLE] & (r_state == DISABLED));

endmodule

// File: tb/tb_i2s_stream_scheduler.sv
// Directed bench for i2s_stream_scheduler: sequencing, FIFO, config and DAC paths.
module tb_i2s_stream_scheduler;

  logic        clk;
  logic        resetN;
  logic        cfgWrite;
  logic [1:0]  cfgAddr;
  logic [7:0]  cfgWdata;
  logic        cfgBusy, overrun, underrun, i2sReset;
  logic [3:0]  clockConfig;
  logic [5:0]  adcScale, dacScale;
  logic [11:0] adcData;
  logic        adcDataValid;
  logic [11:0] dacData;
  logic        dacDataValid;
  logic [11:0] rxData;
  logic        rxValid, rxReady;
  logic [11:0] txData;
  logic        txValid, txReady;

  int checks   = 0;
  int failures = 0;

  i2s_stream_scheduler dut (
    .clk          (clk),
    .resetN       (resetN),
    .cfgWrite     (cfgWrite),
    .cfgAddr      (cfgAddr),
    .cfgWdata     (cfgWdata),
    .cfgBusy      (cfgBusy),
    .overrun      (overrun),
    .underrun     (underrun),
    .i2sReset     (i2sReset),
    .clockConfig  (clockConfig),
    .adcScale     (adcScale),
    .dacScale     (dacScale),
    .adcData      (adcData),
    .adcDataValid (adcDataValid),
    .dacData      (dacData),
    .dacDataValid (dacDataValid),
    .rxData       (rxData),
    .rxValid      (rxValid),
    .rxReady      (rxReady),
    .txData       (txData),
    .txValid      (txValid),
    .txReady      (txReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cfgWrite = 1'b1;
    cfgAddr  = a;
    cfgWdata = d;
    @(negedge clk);
    cfgWrite = 1'b0;
  endtask

  // One frame: adcDataValid high for one cycle; returns at the negedge after the tick edge
  task automatic tick(input logic [11:0] d);
    @(negedge clk);
    adcData      = d;
    adcDataValid = 1'b1;
    @(negedge clk);
    adcDataValid = 1'b0;
  endtask

  initial begin
    resetN       = 1'b0;
    cfgWrite     = 1'b0;
    cfgAddr      = '0;
    cfgWdata     = '0;
    adcData      = '0;
    adcDataValid = 1'b0;
    rxReady      = 1'b0;
    txData       = '0;
    txValid      = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_i2sReset", i2sReset, 1);
    chk("rst_cfgBusy", cfgBusy, 0);
    chk("rst_rxValid", rxValid, 0);
    chk("rst_txReady", txReady, 0);
    chk("rst_dacValid", dacDataValid, 0);
    chk("rst_dacData", dacData, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_clockConfig", clockConfig, 0);
    chk("rst_adcScale", adcScale, 24);
    chk("rst_dacScale", dacScale, 24);
    resetN = 1'b1;

    // Enable: two reset cycles, then two settle frames
    cfg_write(2'd3, 8'h01);
    chk("en_busy_disabled", cfgBusy, 1);
    chk("en_i2sReset_disabled", i2sReset, 1);
    @(negedge clk);
    chk("en_i2sReset_c0", i2sReset, 1);
    @(negedge clk);
    chk("en_i2sReset_c1", i2sReset, 1);
    @(negedge clk);
    chk("en_i2sReset_settle", i2sReset, 0);
    chk("en_busy_settle", cfgBusy, 1);
    tick(12'h001);
    chk("settle1_dacValid", dacDataValid, 1);
    chk("settle1_dacData", dacData, 0);
    chk("settle1_busy", cfgBusy, 1);
    @(negedge clk);
    chk("settle1_dacValid_drop", dacDataValid, 0);
    tick(12'h002);
    chk("settle2_busy_run", cfgBusy, 0);
    chk("settle2_dacValid", dacDataValid, 1);
    chk("settle2_dacData", dacData, 0);
    chk("settle2_no_push", rxValid, 0);
    chk("run_txReady", txReady, 1);

    // FIFO fill, overrun on full, clear by control write, then drain
    for (int i = 1; i <= 4; i++) tick(12'(i));
    chk("fifo4_overrun", overrun, 0);
    chk("fifo4_rxValid", rxValid, 1);
    chk("fifo4_head", rxData, 1);
    tick(12'h005);
    tick(12'h006);
    chk("fifo6_overrun", overrun, 1);
    chk("fifo6_head", rxData, 1);
    chk("fifo6_underrun", underrun, 1);
    cfg_write(2'd3, 8'h01);
    chk("clr_overrun", overrun, 0);
    chk("clr_underrun", underrun, 0);
    rxReady = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_valid", rxValid, 1);
      chk("drain_data", rxData, k);
      @(negedge clk);
    end
    chk("drain_empty", rxValid, 0);

    // Scale change applies at the next tick only, without a controller reset
    cfg_write(2'd1, 8'd30);
    chk("scale_before", adcScale, 24);
    chk("scale_busy", cfgBusy, 1);
    @(negedge clk);
    chk("scale_midframe", adcScale, 24);
    tick(12'h007);
    chk("scale_after", adcScale, 30);
    chk("scale_dac_keep", dacScale, 24);
    chk("scale_busy_clear", cfgBusy, 0);
    chk("scale_no_reset", i2sReset, 0);

    // Clock change: tick discarded, controller reset and resettled
    cfg_write(2'd0, 8'h05);
    chk("clk_before", clockConfig, 0);
    chk("clk_busy", cfgBusy, 1);
    tick(12'h055);
    chk("clk_i2sReset_c0", i2sReset, 1);
    chk("clk_applied", clockConfig, 5);
    chk("clk_tick_no_dac", dacDataValid, 0);
    chk("clk_tick_no_push", rxValid, 0);
    @(negedge clk);
    chk("clk_i2sReset_c1", i2sReset, 1);
    @(negedge clk);
    chk("clk_i2sReset_settle", i2sReset, 0);
    chk("clk_busy_settle", cfgBusy, 1);
    tick(12'h056);
    tick(12'h057);
    chk("clk_run_busy", cfgBusy, 0);

    // DAC sources: TX hold, repeat with underrun, loopback, mute
    cfg_write(2'd3, 8'h01);
    chk("dac_underrun_clr", underrun, 0);
    @(negedge clk);
    chk("tx_ready_empty", txReady, 1);
    txData  = 12'h123;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    chk("tx_ready_full", txReady, 0);
    tick(12'h0AA);
    chk("tx_dacData", dacData, 12'h123);
    chk("tx_dacValid", dacDataValid, 1);
    chk("tx_no_underrun", underrun, 0);
    @(negedge clk);
    chk("tx_dacValid_drop", dacDataValid, 0);
    chk("tx_dacData_stable", dacData, 12'h123);
    chk("tx_ready_again", txReady, 1);
    tick(12'h0AB);
    chk("rep_dacData", dacData, 12'h123);
    chk("rep_dacValid", dacDataValid, 1);
    chk("rep_underrun", underrun, 1);
    cfg_write(2'd3, 8'h03);
    tick(12'h2B4);
    chk("loop_dacData", dacData, 12'h2B4);
    cfg_write(2'd3, 8'h07);
    tick(12'h3C3);
    chk("mute_dacData", dacData, 0);

    // Async reset in RUN with full FIFO
    cfg_write(2'd3, 8'h03);
    rxReady = 1'b0;
    for (int i = 0; i < 5; i++) tick(12'h100 + 12'(i));
    chk("pre_rst_rxValid", rxValid, 1);
    chk("pre_rst_overrun", overrun, 1);
    chk("pre_rst_dacData", dacData, 12'h104);
    #2;
    resetN = 1'b0;
    #1;
    chk("arst_i2sReset", i2sReset, 1);
    chk("arst_rxValid", rxValid, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_dacData", dacData, 0);
    chk("arst_dacValid", dacDataValid, 0);
    chk("arst_txReady", txReady, 0);
    chk("arst_cfgBusy", cfgBusy, 0);
    chk("arst_clockConfig", clockConfig, 0);
    chk("arst_adcScale", adcScale, 24);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
